// File: rtl/bus_cycle_logger.sv
// rtl/bus_cycle_logger.sv - Vector-06c bus cycle classifier feeding a FWFT trace record FIFO
module bus_cycle_logger #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [15:0]           type_mask,
    input  logic                  posedge_strob_sost,
    input  logic [7:0]            status,
    input  logic [15:0]           addr,
    input  logic                  addr_valid,
    input  logic [7:0]            shavv,
    input  logic [7:0]            data,
    input  logic                  negedge_zpzu_n,
    input  logic                  negedge_zpvv_n,
    input  logic                  posedge_chtzu_n,
    input  logic                  posedge_chtvv_n,
    input  logic                  rd,
    output logic [31:0]           rec_data,
    output logic                  rec_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_ovf
);
    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [7:0]          TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0] PTR_ONE    = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WAIT_IO, EMIT} state_t;

    function automatic logic [3:0] classify(input logic [7:0] s);
        logic [3:0] t;
        if (s[0])                          t = 4'h8;
        else if (s[5])                     t = 4'h1;
        else if (s[2] && s[7])             t = 4'h6;
        else if (s[2] && !s[1])            t = 4'h7;
        else if (s[7])                     t = 4'h2;
        else if (!s[1] && !s[4] && !s[6])  t = 4'h3;
        else if (s[6])                     t = 4'h4;
        else if (s[4])                     t = 4'h5;
        else                               t = 4'hF;
        return t;
    endfunction

    state_t      state;
    logic [7:0]  timer;
    logic [3:0]  cur_type;
    logic        cur_timeout;
    logic [15:0] cur_addr;
    logic [7:0]  cur_data;
    logic        pend;
    logic [7:0]  pend_status;

    logic [7:0]  ld_status;
    logic [3:0]  ld_type;
    state_t      ld_state;
    logic        mem_done;
    logic        io_done;
    logic        timer_hit;

    // A strobe arriving during EMIT is newer than any pending one, so it takes priority.
    always_comb begin
        ld_status = (state == EMIT && !posedge_strob_sost) ? pend_status : status;
        ld_type   = classify(ld_status);
        case (ld_type)
            4'h1, 4'h2, 4'h3, 4'h6, 4'h7: ld_state = WAIT_MEM;
            4'h4, 4'h5:                   ld_state = WAIT_IO;
            default:                      ld_state = EMIT;
        endcase
        mem_done  = (cur_type == 4'h3 || cur_type == 4'h7) ? negedge_zpzu_n : posedge_chtzu_n;
        io_done   = (cur_type == 4'h5) ? negedge_zpvv_n : posedge_chtvv_n;
        timer_hit = (timer == TIMER_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            timer       <= '0;
            cur_type    <= '0;
            cur_timeout <= 1'b0;
            cur_addr    <= '0;
            cur_data    <= '0;
            pend        <= 1'b0;
            pend_status <= '0;
        end else if (!enable) begin
            state <= IDLE;
            pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (posedge_strob_sost) begin
                        state       <= ld_state;
                        cur_type    <= ld_type;
                        cur_timeout <= 1'b0;
                        cur_addr    <= '0;
                        cur_data    <= ld_status;
                        timer       <= '0;
                    end
                end
                WAIT_MEM, WAIT_IO: begin
                    if (state == WAIT_MEM && addr_valid)
                        cur_addr <= addr;
                    if (posedge_strob_sost) begin
                        pend        <= 1'b1;
                        pend_status <= status;
                    end
                    // Completion beats a simultaneous strobe; the strobe then only opens the next record.
                    if ((state == WAIT_MEM) ? mem_done : io_done) begin
                        cur_data <= data;
                        if (state == WAIT_IO)
                            cur_addr <= {shavv, shavv};
                        state <= EMIT;
                    end else if (posedge_strob_sost || timer_hit) begin
                        cur_timeout <= 1'b1;
                        cur_data    <= 8'hFF;
                        state       <= EMIT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                EMIT: begin
                    pend <= 1'b0;
                    if (posedge_strob_sost || pend) begin
                        state       <= ld_state;
                        cur_type    <= ld_type;
                        cur_timeout <= 1'b0;
                        cur_addr    <= '0;
                        cur_data    <= ld_status;
                        timer       <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [31:0]         mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DEPTH_LOG2:0] next_rd;
    logic [DEPTH_LOG2:0] next_count;
    logic [31:0]         push_word;
    logic [31:0]         head_next;
    logic                emit_req;
    logic                empty;
    logic                full;
    logic                do_pop;
    logic                do_push;
    logic                drop;

    always_comb begin
        push_word  = {cur_type, cur_timeout, 3'b000, cur_addr, cur_data};
        emit_req   = enable && (state == EMIT) && type_mask[cur_type];
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
        do_pop     = rd && !empty;
        do_push    = emit_req && (!full || do_pop);
        drop       = emit_req && full && !do_pop;
        next_rd    = do_pop ? rd_ptr + PTR_ONE : rd_ptr;
        next_count = (do_push ? wr_ptr + PTR_ONE : wr_ptr) - next_rd;
        // The head register must already show a record pushed into an empty FIFO.
        if (next_count == '0)
            head_next = '0;
        else if (next_rd == wr_ptr)
            head_next = push_word;
        else
            head_next = mem[next_rd[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rec_data <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr   <= next_rd;
            rec_data <= head_next;
            overflow <= drop || (overflow && !clr_ovf);
        end
    end

    assign rec_valid = !empty;
    assign count     = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_bus_cycle_logger.sv
// tb/tb_bus_cycle_logger.sv - directed and randomized checks of bus_cycle_logger against a record-queue model
`timescale 1ns/1ps
module tb_bus_cycle_logger;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] type_mask;
    logic        posedge_strob_sost;
    logic [7:0]  status;
    logic [15:0] addr;
    logic        addr_valid;
    logic [7:0]  shavv;
    logic [7:0]  data;
    logic        negedge_zpzu_n;
    logic        negedge_zpvv_n;
    logic        posedge_chtzu_n;
    logic        posedge_chtvv_n;
    logic        rd;
    logic [31:0] rec_data;
    logic        rec_valid;
    logic [4:0]  count;
    logic        overflow;
    logic        clr_ovf;

    always #5 clk = ~clk;

    bus_cycle_logger #(.DEPTH_LOG2(4), .TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .type_mask(type_mask),
        .posedge_strob_sost(posedge_strob_sost), .status(status),
        .addr(addr), .addr_valid(addr_valid), .shavv(shavv), .data(data),
        .negedge_zpzu_n(negedge_zpzu_n), .negedge_zpvv_n(negedge_zpvv_n),
        .posedge_chtzu_n(posedge_chtzu_n), .posedge_chtvv_n(posedge_chtvv_n),
        .rd(rd), .rec_data(rec_data), .rec_valid(rec_valid), .count(count),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mq[$];

    // Status classification as a first-match rule table: (status & care) == want.
    localparam logic [7:0] CARE [8] = '{8'h01, 8'h20, 8'h84, 8'h06, 8'h80, 8'h52, 8'h40, 8'h10};
    localparam logic [7:0] WANT [8] = '{8'h01, 8'h20, 8'h84, 8'h04, 8'h80, 8'h00, 8'h40, 8'h10};
    localparam logic [3:0] KIND [8] = '{4'h8,  4'h1,  4'h6,  4'h7,  4'h2,  4'h3,  4'h4,  4'h5};

    function automatic logic [3:0] ref_type(input logic [7:0] s);
        for (int i = 0; i < 8; i++)
            if ((s & CARE[i]) == WANT[i]) return KIND[i];
        return 4'hF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic model_push(input logic [31:0] r);
        if (type_mask[r[31:28]] && mq.size() < 16)
            mq.push_back(r);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        e = (mq.size() > 0) ? mq.pop_front() : 32'hBAD0_0000;
        check({tag, "_valid"}, {31'd0, rec_valid}, 32'd1);
        check(tag, rec_data, e);
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    // Drives one complete bus cycle and ends one clock after the record becomes visible.
    task automatic run_txn(input logic [7:0] s, input bit use_addr, input logic [15:0] a,
                           input logic [7:0] sh, input logic [7:0] d);
        logic [3:0]  t;
        logic [31:0] r;
        t = ref_type(s);
        status = s;
        posedge_strob_sost = 1'b1;
        tick();
        posedge_strob_sost = 1'b0;
        if (t inside {4'h1, 4'h2, 4'h3, 4'h6, 4'h7}) begin
            if (use_addr) begin
                addr = 16'hDEAD; addr_valid = 1'b1; tick();
                addr = a; tick();
                addr_valid = 1'b0;
            end
            posedge_chtvv_n = 1'b1; tick(); posedge_chtvv_n = 1'b0;
            data = d;
            if (t inside {4'h3, 4'h7}) negedge_zpzu_n = 1'b1;
            else                       posedge_chtzu_n = 1'b1;
            tick();
            negedge_zpzu_n = 1'b0; posedge_chtzu_n = 1'b0;
            r = {t, 4'h0, (use_addr ? a : 16'h0000), d};
        end else if (t inside {4'h4, 4'h5}) begin
            shavv = sh; data = d;
            if (t == 4'h4) posedge_chtvv_n = 1'b1;
            else           negedge_zpvv_n = 1'b1;
            tick();
            posedge_chtvv_n = 1'b0; negedge_zpvv_n = 1'b0;
            r = {t, 4'h0, sh, sh, d};
        end else begin
            r = {t, 4'h0, 16'h0000, s};
        end
        tick();
        model_push(r);
    endtask

    initial begin
        int n;
        logic [7:0] mix [3];
        reset_n = 1'b0; enable = 1'b0; type_mask = 16'hFFFF;
        posedge_strob_sost = 1'b0; status = 8'h00; addr = 16'h0; addr_valid = 1'b0;
        shavv = 8'h00; data = 8'h00; negedge_zpzu_n = 1'b0; negedge_zpvv_n = 1'b0;
        posedge_chtzu_n = 1'b0; posedge_chtvv_n = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
        mix[0] = 8'hA2; mix[1] = 8'h00; mix[2] = 8'h10;
        #12;
        check("reset_valid", {31'd0, rec_valid}, 32'd0);
        check("reset_count", {27'd0, count}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        check("reset_data", rec_data, 32'd0);
        reset_n = 1'b1;
        tick();
        enable = 1'b1;

        // MEMRD with exact completion-to-output latency
        status = 8'h82; posedge_strob_sost = 1'b1; tick(); posedge_strob_sost = 1'b0;
        addr = 16'h1234; addr_valid = 1'b1; tick(); addr_valid = 1'b0;
        data = 8'h5A; posedge_chtzu_n = 1'b1; tick(); posedge_chtzu_n = 1'b0;
        check("memrd_n1_valid", {31'd0, rec_valid}, 32'd0);
        tick();
        check("memrd_n2_valid", {31'd0, rec_valid}, 32'd1);
        check("memrd_data", rec_data, 32'h2012345A);
        rd = 1'b1; tick(); rd = 1'b0;
        check("memrd_popped", {27'd0, count}, 32'd0);

        run_txn(8'h10, 1'b0, 16'h0, 8'h18, 8'hC3);
        check("iowr_data", rec_data, 32'h501818C3);
        pop_check("iowr");

        // MEMWR with no completion closes on timeout
        status = 8'h00; posedge_strob_sost = 1'b1; tick(); posedge_strob_sost = 1'b0;
        repeat (200) tick();
        check("timeout_early", {27'd0, count}, 32'd0);
        repeat (100) tick();
        check("timeout_count", {27'd0, count}, 32'd1);
        mq.push_back(32'h380000FF);
        pop_check("timeout_rec");

        // New strobe while waiting: current closes with timeout, new one proceeds
        status = 8'h82; posedge_strob_sost = 1'b1; tick(); posedge_strob_sost = 1'b0;
        addr = 16'hABCD; addr_valid = 1'b1; tick(); addr_valid = 1'b0;
        status = 8'h10; posedge_strob_sost = 1'b1; tick(); posedge_strob_sost = 1'b0;
        tick();
        shavv = 8'h22; data = 8'h11; negedge_zpvv_n = 1'b1; tick(); negedge_zpvv_n = 1'b0;
        tick();
        check("b2b_count", {27'd0, count}, 32'd2);
        mq.push_back(32'h28ABCDFF); mq.push_back(32'h50222211);
        pop_check("b2b_first"); pop_check("b2b_second");

        // Completion and strobe in the same clock
        status = 8'h00; posedge_strob_sost = 1'b1; tick();
        data = 8'h77; negedge_zpzu_n = 1'b1; status = 8'hA2; tick();
        posedge_strob_sost = 1'b0; negedge_zpzu_n = 1'b0;
        tick();
        addr = 16'h0100; addr_valid = 1'b1; tick(); addr_valid = 1'b0;
        data = 8'h99; posedge_chtzu_n = 1'b1; tick(); posedge_chtzu_n = 1'b0;
        tick();
        mq.push_back(32'h30000077); mq.push_back(32'h10010099);
        pop_check("same_clk_done"); pop_check("same_clk_next");

        rd = 1'b1; tick(); rd = 1'b0;
        check("rd_empty_count", {27'd0, count}, 32'd0);
        check("rd_empty_valid", {31'd0, rec_valid}, 32'd0);

        // Dropping enable discards the in-flight cycle but keeps stored records
        run_txn(8'hA2, 1'b0, 16'h0, 8'h0, 8'h42);
        status = 8'h82; posedge_strob_sost = 1'b1; tick(); posedge_strob_sost = 1'b0;
        enable = 1'b0; tick();
        data = 8'h13; posedge_chtzu_n = 1'b1; tick(); posedge_chtzu_n = 1'b0;
        tick(); tick();
        enable = 1'b1; tick();
        check("enable_count", {27'd0, count}, 32'd1);
        pop_check("enable_keep");

        // Overflow, clear, then full with simultaneous push and pop
        for (int i = 0; i < 17; i++) run_txn(8'hA2, 1'b0, 16'h0, 8'h0, 8'(i));
        check("full_count", {27'd0, count}, 32'd16);
        check("full_ovf", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        status = 8'hA2; posedge_strob_sost = 1'b1; tick(); posedge_strob_sost = 1'b0;
        data = 8'hEE; posedge_chtzu_n = 1'b1; tick(); posedge_chtzu_n = 1'b0;
        rd = 1'b1; tick(); rd = 1'b0;
        void'(mq.pop_front());
        mq.push_back(32'h100000EE);
        check("full_rw_count", {27'd0, count}, 32'd16);
        check("full_rw_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) pop_check($sformatf("drain_%0d", i));

        // Type mask lets only FETCH through
        type_mask = 16'h0002;
        for (int i = 0; i < 8; i++)
            run_txn(mix[$urandom_range(0, 2)], 1'b1, 16'($urandom), 8'($urandom), 8'($urandom));
        check("mask_count", {27'd0, count}, mq.size());
        while (mq.size() > 0) pop_check("mask_rec");
        type_mask = 16'hFFFF;

        // Random cycles in small bursts
        for (int b = 0; b < 20; b++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++)
                run_txn(8'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
            check("rnd_count", {27'd0, count}, n);
            while (mq.size() > 0) pop_check("rnd_rec");
        end

        // Asynchronous reset mid-operation
        run_txn(8'hA2, 1'b0, 16'h0, 8'h0, 8'h01);
        run_txn(8'h82, 1'b1, 16'h4444, 8'h0, 8'h02);
        #3;
        reset_n = 1'b0;
        #1;
        check("areset_count", {27'd0, count}, 32'd0);
        check("areset_valid", {31'd0, rec_valid}, 32'd0);
        check("areset_data", rec_data, 32'd0);
        mq.delete();
        #2;
        reset_n = 1'b1;
        tick();
        run_txn(8'h40, 1'b0, 16'h0, 8'h5C, 8'h66);
        pop_check("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
